// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch and data-access ports of the
//   core. One transaction at a time is sequenced through a req/ack handshake, with a timeout
//   guarding against a memory that never answers.
//
// Ports
//   clk, rst_n            clock (rising edge) and synchronous active-low reset
//   i_inst_*              fetch request (nonzero byte enables = request) and address
//   o_instr_ready/_data   fetch not pending or completing; fetched word on completion
//   i_data_*              data read/write request, byte enables, address, write data
//   o_data_ready/_rd      data access not pending or completing; read word on completion
//   o_mem_*, i_mem_*      memory request side; request held until ack or timeout
//   o_bus_error           one-cycle pulse when a transaction times out
//   o_err_count           saturating count of timeouts
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            i_inst_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_inst_addr,
    output logic                  o_instr_ready,
    output logic [DATA_WIDTH-1:0] o_instr_data,
    input  logic                  i_data_rd_en_ma,
    input  logic                  i_data_wr_en_ma,
    input  logic [3:0]            i_data_rd_en_ctrl,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic [DATA_WIDTH-1:0] i_data_wr,
    output logic                  o_data_ready,
    output logic [DATA_WIDTH-1:0] o_data_rd,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_be,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_bus_error,
    output logic [7:0]            o_err_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   to_cnt_q;
    logic [SW-1:0]   streak_q;
    logic            inst_done_q, data_done_q;
    logic            inst_req, data_req, inst_act, data_act;
    logic            grant_i, grant_d, busy, timeout, finish, streak_full;

    assign inst_req = |i_inst_rd_en;
    assign data_req = i_data_rd_en_ma | i_data_wr_en_ma;
    // A requester whose access completes this cycle is still holding its request; mask it.
    assign inst_act = inst_req & ~inst_done_q;
    assign data_act = data_req & ~data_done_q;

    assign streak_full = (streak_q == SW'(MAX_DATA_STREAK));
    assign busy        = (state_q != StIdle);
    // to_cnt_q counts completed busy cycles; the last allowed cycle is TIMEOUT_CYCLES-1.
    assign timeout     = busy & ~i_mem_ack & (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign finish      = busy & (i_mem_ack | timeout);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_act && (!inst_act || !streak_full)) begin
                    state_d = StBusyD;
                    grant_d = 1'b1;
                end else if (inst_act) begin
                    state_d = StBusyI;
                    grant_i = 1'b1;
                end
            end
            StBusyI, StBusyD: begin
                if (finish) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        o_instr_ready = ~inst_req | inst_done_q;
        o_data_ready  = ~data_req | data_done_q;
    end

    // Counters, memory-side registers and completion datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q     <= '0;
            streak_q     <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_be     <= '0;
            o_instr_data <= '0;
            o_data_rd    <= '0;
            o_bus_error  <= 1'b0;
            o_err_count  <= '0;
        end else begin
            if (!busy || finish) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end

            // Streak only matters while a fetch is waiting behind data grants.
            if (!inst_req || grant_i) begin
                streak_q <= '0;
            end else if (grant_d && !streak_full) begin
                streak_q <= streak_q + SW'(1);
            end

            if (grant_d) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= i_data_wr_en_ma;
                o_mem_addr  <= i_data_addr;
                o_mem_wdata <= i_data_wr;
                o_mem_be    <= i_data_rd_en_ctrl;
            end else if (grant_i) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= 1'b0;
                o_mem_addr  <= i_inst_addr;
                o_mem_wdata <= '0;
                o_mem_be    <= i_inst_rd_en;
            end else if (finish) begin
                o_mem_req   <= 1'b0;
            end

            inst_done_q <= finish & (state_q == StBusyI);
            data_done_q <= finish & (state_q == StBusyD);

            if (finish && state_q == StBusyI) o_instr_data <= i_mem_ack ? i_mem_rdata : '0;
            if (finish && state_q == StBusyD) o_data_rd    <= i_mem_ack ? i_mem_rdata : '0;

            o_bus_error <= timeout;
            if (timeout && o_err_count != 8'd255) o_err_count <= o_err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    i_inst_rd_en;
    logic [AW-1:0] i_inst_addr;
    logic          o_instr_ready;
    logic [DW-1:0] o_instr_data;
    logic          i_data_rd_en_ma, i_data_wr_en_ma;
    logic [3:0]    i_data_rd_en_ctrl;
    logic [AW-1:0] i_data_addr;
    logic [DW-1:0] i_data_wr;
    logic          o_data_ready;
    logic [DW-1:0] o_data_rd;
    logic          o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [3:0]    o_mem_be;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;
    logic          o_bus_error;
    logic [7:0]    o_err_count;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .MAX_DATA_STREAK(MS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_inst_rd_en(i_inst_rd_en), .i_inst_addr(i_inst_addr),
        .o_instr_ready(o_instr_ready), .o_instr_data(o_instr_data),
        .i_data_rd_en_ma(i_data_rd_en_ma), .i_data_wr_en_ma(i_data_wr_en_ma),
        .i_data_rd_en_ctrl(i_data_rd_en_ctrl), .i_data_addr(i_data_addr),
        .i_data_wr(i_data_wr), .o_data_ready(o_data_ready), .o_data_rd(o_data_rd),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_bus_error(o_bus_error), .o_err_count(o_err_count)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
    } mem_t;

    // Scoreboard queues: expected memory requests and expected completion words.
    mem_t          mem_q[$];
    logic [DW-1:0] iq[$];
    logic [DW-1:0] dq[$];

    // Reference model: who owns the memory, how long, and what the core should see.
    int            m_owner;      // 0 none, 1 fetch, 2 data
    int            m_cnt;
    int            m_streak;
    int            m_err;
    int            ack_delay;
    bit            m_idone, m_ddone, m_berr;
    mem_t          m_cur;
    logic [DW-1:0] m_idata, m_ddata;

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, independent of the stimulus process.
    mem_t held;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (run) begin
            chk("mem_req", 64'(o_mem_req), 64'(m_owner != 0));
            if (o_mem_req && !prev_req) begin
                if (mem_q.size() == 0) begin
                    chk("grant_expected", 64'(1), 64'(0));
                end else begin
                    held = mem_q.pop_front();
                    chk("grant_we", 64'(o_mem_we), 64'(held.we));
                    chk("grant_addr", 64'(o_mem_addr), 64'(held.addr));
                    chk("grant_be", 64'(o_mem_be), 64'(held.be));
                    if (held.we) chk("grant_wdata", 64'(o_mem_wdata), 64'(held.wdata));
                end
            end
            // Memory-side fields: held while busy, zero after reset until the next grant.
            chk("mem_we", 64'(o_mem_we), 64'(m_cur.we));
            chk("mem_addr", 64'(o_mem_addr), 64'(m_cur.addr));
            chk("mem_be", 64'(o_mem_be), 64'(m_cur.be));
            if (m_cur.we || m_cur == '0) chk("mem_wdata", 64'(o_mem_wdata), 64'(m_cur.wdata));

            chk("instr_ready", 64'(o_instr_ready), 64'(!(|i_inst_rd_en) || m_idone));
            chk("data_ready", 64'(o_data_ready),
                64'(!(i_data_rd_en_ma || i_data_wr_en_ma) || m_ddone));
            if ((|i_inst_rd_en) && o_instr_ready) begin
                if (iq.size() == 0) chk("instr_done_expected", 64'(1), 64'(0));
                else chk("instr_done_data", 64'(o_instr_data), 64'(iq.pop_front()));
            end
            if ((i_data_rd_en_ma || i_data_wr_en_ma) && o_data_ready) begin
                if (dq.size() == 0) chk("data_done_expected", 64'(1), 64'(0));
                else chk("data_done_data", 64'(o_data_rd), 64'(dq.pop_front()));
            end
            chk("instr_data_hold", 64'(o_instr_data), 64'(m_idata));
            chk("data_rd_hold", 64'(o_data_rd), 64'(m_ddata));
            chk("bus_error", 64'(o_bus_error), 64'(m_berr));
            chk("err_count", 64'(o_err_count), 64'(m_err));
            prev_req = o_mem_req;
        end
    end

    function automatic void model_reset();
        m_owner = 0; m_cnt = 0; m_streak = 0; m_err = 0; ack_delay = 0;
        m_idone = 0; m_ddone = 0; m_berr = 0;
        m_cur = '0; m_idata = '0; m_ddata = '0;
        mem_q.delete(); iq.delete(); dq.delete();
    endfunction

    function automatic void complete(input logic [DW-1:0] word, output bit id, output bit dd);
        id = 0; dd = 0;
        if (m_owner == 1) begin iq.push_back(word); m_idata = word; id = 1; end
        else              begin dq.push_back(word); m_ddata = word; dd = 1; end
        m_owner = 0;
    endfunction

    // One clock of the arbitration rules, using the inputs about to be sampled.
    function automatic void model_step();
        bit inst_req, data_req, ie, de, id, dd;
        int g;
        inst_req = |i_inst_rd_en;
        data_req = i_data_rd_en_ma || i_data_wr_en_ma;
        id = 0; dd = 0; m_berr = 0;
        if (m_owner == 0) begin
            ie = inst_req && !m_idone;
            de = data_req && !m_ddone;
            g  = 0;
            if (de && (!ie || m_streak != MS)) g = 2;
            else if (ie) g = 1;
            if (g == 2) m_cur = '{we: i_data_wr_en_ma, addr: i_data_addr,
                                  wdata: i_data_wr, be: i_data_rd_en_ctrl};
            if (g == 1) m_cur = '{we: 1'b0, addr: i_inst_addr, wdata: '0, be: i_inst_rd_en};
            if (g != 0) begin
                mem_q.push_back(m_cur);
                m_owner   = g;
                m_cnt     = 0;
                ack_delay = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 3));
            end
            if (!inst_req || g == 1) m_streak = 0;
            else if (g == 2 && m_streak < MS) m_streak++;
        end else begin
            if (!inst_req) m_streak = 0;
            if (i_mem_ack) begin
                complete(i_mem_rdata, id, dd);
            end else if (m_cnt + 1 == TO) begin
                complete('0, id, dd);
                m_berr = 1;
                if (m_err < 255) m_err++;
            end else begin
                m_cnt++;
            end
        end
        m_idone = id;
        m_ddone = dd;
    endfunction

    // Core and memory behaviour
    bit         i_act, i_cmp, d_act, d_cmp, want_rst, stray;
    logic [3:0] i_en, d_be;
    logic [31:0] i_adr, d_adr, d_wd;
    logic       d_rd, d_wr;
    int         quiet;

    initial begin
        rst_n = 1'b0; i_inst_rd_en = '0; i_inst_addr = '0; i_data_rd_en_ma = 1'b0;
        i_data_wr_en_ma = 1'b0; i_data_rd_en_ctrl = '0; i_data_addr = '0; i_data_wr = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        i_act = 0; i_cmp = 0; d_act = 0; d_cmp = 0; want_rst = 0; stray = 0; quiet = 0;
        model_reset();
        @(posedge clk); @(posedge clk);
        run = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk); #2;
            if (cyc == 1500 || cyc == 3500) want_rst = 1;
            if (want_rst && m_owner != 0 && m_cnt >= 1) begin
                // Abandon an in-flight transaction; the next cycle carries a stray ack.
                want_rst = 0;
                rst_n = 1'b0;
                i_act = 0; i_cmp = 0; d_act = 0; d_cmp = 0;
                i_inst_rd_en = '0; i_data_rd_en_ma = 1'b0; i_data_wr_en_ma = 1'b0;
                i_mem_ack = 1'b0;
                model_reset();
                stray = 1; quiet = 4;
                continue;
            end
            rst_n = 1'b1;
            if (quiet > 0) quiet--;

            if (i_cmp) begin i_act = 0; i_cmp = 0; end
            if (m_idone) i_cmp = 1;
            else if (!i_act && quiet == 0 && $urandom_range(0, 2) == 0) begin
                i_act = 1; i_en = 4'($urandom_range(1, 15)); i_adr = $urandom;
            end
            i_inst_rd_en = i_act ? i_en : 4'h0;
            i_inst_addr  = i_act ? i_adr : $urandom;

            if (d_cmp) begin d_act = 0; d_cmp = 0; end
            if (m_ddone) d_cmp = 1;
            else if (!d_act && quiet == 0 && $urandom_range(0, 2) == 0) begin
                d_act = 1;
                case ($urandom_range(0, 3))
                    0:       begin d_rd = 1; d_wr = 0; end
                    1:       begin d_rd = 0; d_wr = 1; end
                    2:       begin d_rd = 1; d_wr = 1; end
                    default: begin d_rd = 1; d_wr = 0; end
                endcase
                d_be = 4'($urandom); d_adr = $urandom; d_wd = $urandom;
            end
            i_data_rd_en_ma   = d_act ? d_rd : 1'b0;
            i_data_wr_en_ma   = d_act ? d_wr : 1'b0;
            i_data_rd_en_ctrl = d_act ? d_be : 4'($urandom);
            i_data_addr       = d_act ? d_adr : $urandom;
            i_data_wr         = d_act ? d_wd : $urandom;

            i_mem_rdata = $urandom;
            if (m_owner != 0 && m_cnt == ack_delay) i_mem_ack = 1'b1;
            else if (stray) i_mem_ack = 1'b1;
            else if (m_owner == 0 && $urandom_range(0, 15) == 0) i_mem_ack = 1'b1;
            else i_mem_ack = 1'b0;
            stray = 0;

            model_step();
        end
        @(negedge clk); #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
